acc_cpu: RTL and testbench

- Two-state, multicycle accumulator processor that masters the shared 16-bit instruction/data memory.
- Drives the 12-bit address, the write strobe and the bidirectional 16-bit data bus of the memory directly downstream.
- Executes the opcodes package instruction set: LDA, STA, ADD, SUB, JMP, JMPZ.
- Instruction word is {opcode[15:12], operand[11:0]}; opcode encodings per the opcodes package.

---
 rtl/acc_cpu.sv | 121 ++++++++++++
 tb/tb_acc_cpu.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu.sv
`default_nettype none
// ============================================================================
// Module   : acc_cpu
// Brief    : Two-state (FETCH/EXEC) multicycle accumulator processor that
//            masters a shared instruction/data memory over a tri-state bus.
// Revision : 1.0 - initial release
// ============================================================================
module acc_cpu #(
    parameter int AW       = 12,
    parameter int DW       = 16,
    parameter int RESET_PC = 0
) (
    input  logic          clock,
    input  logic          nReset,
    output logic [AW-1:0] address,
    inout  wire  [DW-1:0] data,
    output logic          write,
    output logic [DW-1:0] acc,
    output logic [AW-1:0] pc,
    output logic          halted
);

    localparam logic [0:0]    c_FETCH    = 1'b0;
    localparam logic [0:0]    c_EXEC     = 1'b1;
    localparam logic [3:0]    c_OP_LDA   = 4'h1;
    localparam logic [3:0]    c_OP_STA   = 4'h2;
    localparam logic [3:0]    c_OP_ADD   = 4'h3;
    localparam logic [3:0]    c_OP_SUB   = 4'h4;
    localparam logic [3:0]    c_OP_JMP   = 4'h5;
    localparam logic [3:0]    c_OP_JMPZ  = 4'h6;
    localparam logic [AW-1:0] c_RESET_PC = AW'(RESET_PC);

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_pc_prev;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] w_acc_nxt;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] w_ir_nxt;
    logic          r_halted;
    logic          w_halted_nxt;
    logic          w_write;
    logic [3:0]    w_opcode;
    logic [AW-1:0] w_operand;

    assign w_opcode  = r_ir[DW-1 -: 4];
    assign w_operand = r_ir[AW-1:0];
    // pc has already advanced past the instruction being executed
    assign w_pc_prev = r_pc - 1'b1;

    always_ff @(posedge clock) begin
        if (!nReset) begin
            r_state  <= c_FETCH;
            r_pc     <= c_RESET_PC;
            r_acc    <= '0;
            r_ir     <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_acc    <= w_acc_nxt;
            r_ir     <= w_ir_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_acc_nxt    = r_acc;
        w_ir_nxt     = r_ir;
        w_halted_nxt = r_halted;
        case (r_state)
            c_FETCH: begin
                w_ir_nxt    = data;
                w_pc_nxt    = r_pc + 1'b1;
                w_state_nxt = c_EXEC;
            end
            default: begin
                w_state_nxt = c_FETCH;
                case (w_opcode)
                    c_OP_LDA: w_acc_nxt = data;
                    c_OP_ADD: w_acc_nxt = r_acc + data;
                    c_OP_SUB: w_acc_nxt = r_acc - data;
                    c_OP_JMP: begin
                        w_pc_nxt = w_operand;
                        if (w_operand == w_pc_prev) begin
                            w_halted_nxt = 1'b1;
                        end
                    end
                    c_OP_JMPZ: begin
                        if (r_acc == '0) begin
                            w_pc_nxt = w_operand;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

    // The bus is only ever driven for STA in EXEC, and never while in reset
    always_comb begin
        address = r_pc;
        w_write = 1'b0;
        if (r_state == c_EXEC) begin
            address = w_operand;
            w_write = nReset && (w_opcode == c_OP_STA);
        end
    end

    assign data   = w_write ? r_acc : {DW{1'bz}};
    assign write  = w_write;
    assign acc    = r_acc;
    assign pc     = r_pc;
    assign halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_acc_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_cpu
// Brief    : Self-checking bench for acc_cpu; instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_cpu;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam logic [3:0] c_LDA  = 4'h1;
    localparam logic [3:0] c_STA  = 4'h2;
    localparam logic [3:0] c_ADD  = 4'h3;
    localparam logic [3:0] c_SUB  = 4'h4;
    localparam logic [3:0] c_JMP  = 4'h5;
    localparam logic [3:0] c_JMPZ = 4'h6;

    logic          clock = 1'b0;
    logic          nReset = 1'b0;
    logic [AW-1:0] address;
    wire  [DW-1:0] data;
    logic          write;
    logic [DW-1:0] acc;
    logic [AW-1:0] pc;
    logic          halted;

    logic [DW-1:0] mem     [0:4095];
    logic [DW-1:0] ref_mem [0:4095];

    int n_checks = 0;
    int n_pass   = 0;
    int n_edges  = 0;

    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_acc;
    logic          m_halt;

    acc_cpu #(.AW(AW), .DW(DW), .RESET_PC(0)) dut (
        .clock   (clock),
        .nReset  (nReset),
        .address (address),
        .data    (data),
        .write   (write),
        .acc     (acc),
        .pc      (pc),
        .halted  (halted)
    );

    always #5 clock = ~clock;

    // Combinational memory read; released whenever the CPU writes
    assign data = write ? {DW{1'bz}} : mem[address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one rising edge; memory captures what the bus held before it
    task automatic step();
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        we = write;
        a  = address;
        d  = data;
        @(posedge clock);
        #1;
        n_edges++;
        if (we) mem[a] = d;
    endtask

    function automatic logic [DW-1:0] enc(input logic [3:0] op, input logic [AW-1:0] opnd);
        return {op, opnd};
    endfunction

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_write", write, 0);
            step();
        end
        chk("rst_pc", pc, 0);
        chk("rst_acc", acc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_write_end", write, 0);
        nReset = 1'b1;
        #1;
        chk("rst_first_fetch", address, 0);
        m_pc    = '0;
        m_acc   = '0;
        m_halt  = 1'b0;
        n_edges = 0;
    endtask

    // One whole instruction: check both bus phases, then the architectural state
    task automatic run_instr();
        logic [DW-1:0] ir;
        logic [3:0]    op;
        logic [AW-1:0] opnd;
        logic [AW-1:0] here;
        here = m_pc;
        chk("fetch_addr", address, here);
        chk("fetch_write", write, 0);
        step();
        ir   = ref_mem[here];
        op   = ir[15:12];
        opnd = ir[11:0];
        m_pc = here + 12'd1;
        chk("exec_addr", address, opnd);
        chk("exec_write", write, (op == c_STA) ? 1 : 0);
        if (op == c_STA) chk("sta_data", data, m_acc);
        step();
        case (op)
            c_LDA:  m_acc = ref_mem[opnd];
            c_ADD:  m_acc = m_acc + ref_mem[opnd];
            c_SUB:  m_acc = m_acc - ref_mem[opnd];
            c_STA:  ref_mem[opnd] = m_acc;
            c_JMP:  begin
                if (opnd == here) m_halt = 1'b1;
                m_pc = opnd;
            end
            c_JMPZ: if (m_acc == '0) m_pc = opnd;
            default: ;
        endcase
        chk("pc", pc, m_pc);
        chk("acc", acc, m_acc);
        chk("halted", halted, m_halt);
    endtask

    initial begin
        #1;
        // Single arithmetic ops
        clear_mem();
        poke(0, enc(c_LDA, 20));
        poke(1, enc(c_ADD, 21));
        poke(2, enc(c_SUB, 22));
        poke(20, 16'h0005);
        poke(21, 16'h0003);
        poke(22, 16'h0009);
        do_reset();
        run_instr(); chk("lda_val", acc, 16'h0005);
        run_instr(); chk("add_val", acc, 16'h0008);
        run_instr(); chk("sub_wrap", acc, 16'hFFFF);

        // STA bus timing
        clear_mem();
        poke(0, enc(c_LDA, 20));
        poke(1, enc(c_STA, 30));
        poke(20, 16'h1234);
        do_reset();
        run_instr();
        run_instr();
        chk("sta_mem", mem[30], 16'h1234);
        run_instr();

        // JMPZ taken
        clear_mem();
        poke(0, enc(c_LDA, 20));
        poke(1, enc(c_JMPZ, 12));
        do_reset();
        run_instr(); run_instr();
        chk("jmpz_taken", pc, 12);

        // JMPZ not taken
        clear_mem();
        poke(0, enc(c_LDA, 21));
        poke(3, enc(c_JMPZ, 12));
        poke(21, 16'h0001);
        do_reset();
        for (int i = 0; i < 4; i++) run_instr();
        chk("jmpz_not_taken", pc, 4);

        // Self-loop halt is sticky
        clear_mem();
        poke(0, enc(c_JMP, 99));
        poke(99, enc(c_JMP, 99));
        do_reset();
        run_instr(); chk("jmp_not_halt", halted, 0);
        run_instr(); chk("self_loop_halt", halted, 1);
        for (int i = 0; i < 3; i++) run_instr();
        chk("halt_sticky", halted, 1);

        // PC wrap from the top of the address space
        clear_mem();
        poke(0, enc(c_JMP, 12'hFFF));
        do_reset();
        run_instr(); run_instr();
        chk("pc_wrap", pc, 0);

        // Reference program: sum 7+6+...+1
        clear_mem();
        poke(0, enc(c_LDA, 20));   poke(1, enc(c_STA, 22));
        poke(2, enc(c_ADD, 23));   poke(3, enc(c_STA, 22));
        poke(4, enc(c_SUB, 21));   poke(5, enc(c_STA, 24));
        poke(6, enc(c_ADD, 22));   poke(7, enc(c_STA, 22));
        poke(8, enc(c_LDA, 24));   poke(9, enc(c_SUB, 21));
        poke(10, enc(c_JMPZ, 98)); poke(11, enc(c_JMP, 5));
        poke(20, 16'd0); poke(21, 16'd1); poke(23, 16'd7);
        poke(98, enc(c_LDA, 22));  poke(99, enc(c_JMP, 99));
        do_reset();
        while (!halted && n_edges < 400) run_instr();
        chk("ref_edges", n_edges, 96);
        chk("ref_sum_mem", mem[22], 28);
        chk("ref_sum_acc", acc, 28);

        // Reset in the middle of STA
        clear_mem();
        poke(0, enc(c_LDA, 20));
        poke(1, enc(c_STA, 30));
        poke(20, 16'h1234);
        poke(30, 16'hBEEF);
        do_reset();
        run_instr();
        step();
        chk("mid_sta_write_pre", write, 1);
        nReset = 1'b0;
        #1;
        chk("mid_sta_write_rst", write, 0);
        step();
        nReset = 1'b1;
        #1;
        chk("mid_sta_mem", mem[30], 16'hBEEF);
        chk("mid_sta_pc", pc, 0);
        chk("mid_sta_acc", acc, 0);
        chk("mid_sta_restart", address, 0);
        m_pc = '0; m_acc = '0; m_halt = 1'b0;
        run_instr(); run_instr();
        chk("mid_sta_redo", mem[30], 16'h1234);

        // Randomized programs against the reference model
        for (int t = 0; t < 4; t++) begin
            int diffs;
            clear_mem();
            for (int a = 0; a < 64; a++) begin
                logic [DW-1:0] w;
                if ($urandom_range(0, 3) == 0) w = '0;
                else w = enc(4'($urandom_range(0, 7)), 12'($urandom_range(0, 63)));
                poke(12'(a), w);
            end
            do_reset();
            for (int i = 0; i < 40; i++) run_instr();
            diffs = 0;
            for (int a = 0; a < 64; a++) if (mem[a] !== ref_mem[a]) diffs++;
            chk("rand_mem", diffs, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
